chimera_clu_gate_ctrl: RTL and testbench
========================================

// Module: chimera_clu_gate_ctrl
// PURPOSE
// - Per-cluster clock-gate sequencer between the top-level config registers and the cluster clock gates.
// - A register-level gate request becomes a safe sequence: isolate the cluster's AXI ports, wait for drain, settle, gate the clock.
// - An ungate request reverses the sequence: clock on, hold cluster reset, then release isolation.
// - Runs in the SoC clock domain. Drives the tc_clk_gating enables and the cluster-domain isolation/reset.
// PARAMETERS
// - NumClusters   default 5   number of independently gated clusters (one FSM each)
// - SettleCycles  default 4   cycles between drain-complete and clock disable (>=1)
// - RstCycles     default 8   cycles cluster reset is held after clock re-enable (>=1)
// - TimeoutCycles default 1024  drain timeout; used only with CHIMERA_CLU_GATE_TIMEOUT_EN
// PORTS
// - soc_clk_i    in   1            SoC clock; the only clock
// - rst_ni       in   1            asynchronous active-low reset
// - gate_req_i   in   NumClusters  level; 1 = cluster clock is requested off (from cluster_N_clk_gate_en)
// - busy_i       in   NumClusters  cluster has outstanding narrow/wide AXI transactions
// - isolated_i   in   NumClusters  isolation acknowledge from the cluster-domain AXI isolators
// - isolate_o    out  NumClusters  isolation request to the cluster-domain AXI isolators
// - clk_en_o     out  NumClusters  clock-gate enable (1 = clock running) to tc_clk_gating en_i
// - clu_rst_no   out  NumClusters  active-low cluster reset
// - gated_o      out  NumClusters  status: cluster is in the GATED state
// - timeout_o    out  NumClusters  sticky drain-timeout flag (constant 0 without CHIMERA_CLU_GATE_TIMEOUT_EN)
// BEHAVIOUR
// - Reset values:
//   - FSM state = ACTIVE
//   - isolate_o = 0, clk_en_o = 1, clu_rst_no = 1, gated_o = 0, timeout_o = 0
// - All outputs are registered. All per-cluster FSMs are fully independent.
// - ACTIVE: isolate_o=0, clk_en_o=1.
//   - gate_req_i=1 -> ISOLATE next cycle.
// - ISOLATE: isolate_o=1.
//   - isolated_i & ~busy_i -> SETTLE and load the counter with SettleCycles-1.
//   - gate_req_i drops before drain completes -> ACTIVE (abort). isolate_o=0 the cycle after.
// - SETTLE: isolate_o=1. Counter decrements each cycle.
//   - Counter==0 -> GATED. clk_en_o=0 from the first GATED cycle.
//   - gate_req_i changes in SETTLE are ignored until GATED is reached.
// - GATED: clk_en_o=0, isolate_o=1, gated_o=1.
//   - gate_req_i=0 -> WAKE and load the counter with RstCycles-1.
// - WAKE: clk_en_o=1, clu_rst_no=0, isolate_o=1. Counter decrements each cycle.
//   - Counter==0 -> ACTIVE. clu_rst_no=1 and isolate_o=0 in the same cycle.
//   - gate_req_i reasserted in WAKE is served only after ACTIVE is reached (no WAKE->ISOLATE shortcut).
// - Latencies:
//   - gate_req rise to clk_en_o fall: 2+SettleCycles cycles minimum (drain immediate).
//   - gate_req fall to isolate_o fall: 1+RstCycles cycles.
// - Counter width: $clog2(max(SettleCycles,RstCycles,TimeoutCycles)+1). No wrap-around; the counter only counts down to 0.
// - Asynchronous reset mid-sequence returns every FSM to ACTIVE, with the clock running and isolation released.
// CONFIGURATION
// - CHIMERA_CLU_GATE_TIMEOUT_EN defined:
//   - In ISOLATE a counter runs from TimeoutCycles-1.
//   - At 0 the FSM returns to ACTIVE (cluster not gated) and sets timeout_o.
//   - timeout_o is cleared only by a gate_req_i falling edge or by reset.
// - CHIMERA_CLU_GATE_TIMEOUT_EN undefined:
//   - ISOLATE waits indefinitely for drain.
//   - timeout_o is tied to 0 and TimeoutCycles is unused.
// STRUCTURE
// - chimera_pkg gains:
//   - clu_gate_state_e enum: ACTIVE, ISOLATE, SETTLE, GATED, WAKE (3 bits)
//   - default constants CluGateSettleCycles and CluGateRstCycles
// - Sub-module chimera_clu_gate_fsm holds one FSM plus its counter. The top is a generate loop over NumClusters.
// TESTING
// - Gate, idle cluster: gate_req[2]=1, busy=0, isolated=1 next cycle
//   -> isolate_o[2]=1 after 1 cycle; clk_en_o[2]=0 after 2+4 cycles; gated_o[2]=1.
// - Drain wait: busy[0]=1 for 50 cycles after the request
//   -> clk_en_o[0] stays 1 until 50+1+4 cycles, then 0; other clusters unaffected.
// - Abort: gate_req[1] pulses for 3 cycles while busy[1]=1
//   -> returns to ACTIVE; isolate_o[1]=0; clk_en_o[1] never drops.
// - Wake: gate_req[3] falls while GATED
//   -> clk_en_o[3]=1 next cycle; clu_rst_no[3]=0 for exactly 8 cycles; then isolate_o[3]=0.
// - Reset mid-SETTLE: rst_ni=0
//   -> all outputs at their reset values immediately (asynchronous); no clock glitch, clk_en_o=1.
// - With CHIMERA_CLU_GATE_TIMEOUT_EN, TimeoutCycles=16, busy[4] stuck at 1
//   -> after 16 cycles in ISOLATE: timeout_o[4]=1, ACTIVE, clk_en_o[4]=1.

Source files
------------

// File: rtl/chimera_pkg.sv
// Shared Chimera types and defaults for the cluster clock-gate sequencer.
// Holds the per-cluster FSM state encoding and the counter-width helper.
package chimera_pkg;

    typedef enum logic [2:0] {
        ACTIVE  = 3'd0,
        ISOLATE = 3'd1,
        SETTLE  = 3'd2,
        GATED   = 3'd3,
        WAKE    = 3'd4
    } clu_gate_state_e;

    localparam int unsigned CluGateSettleCycles  = 4;
    localparam int unsigned CluGateRstCycles     = 8;
    localparam int unsigned CluGateTimeoutCycles = 1024;

    function automatic int unsigned clu_gate_cnt_w(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/chimera_clu_gate_ctrl_if.sv
// Register/cluster-side bundle of the cluster clock-gate sequencer.
// master = config registers + cluster isolators, slave = sequencer.
interface chimera_clu_gate_ctrl_if #(
    parameter int unsigned NumClusters = 5
);
    logic [NumClusters-1:0] gate_req_i;
    logic [NumClusters-1:0] busy_i;
    logic [NumClusters-1:0] isolated_i;
    logic [NumClusters-1:0] isolate_o;
    logic [NumClusters-1:0] clk_en_o;
    logic [NumClusters-1:0] clu_rst_no;
    logic [NumClusters-1:0] gated_o;
    logic [NumClusters-1:0] timeout_o;

    modport master (
        output gate_req_i, busy_i, isolated_i,
        input  isolate_o, clk_en_o, clu_rst_no, gated_o, timeout_o
    );

    modport slave (
        input  gate_req_i, busy_i, isolated_i,
        output isolate_o, clk_en_o, clu_rst_no, gated_o, timeout_o
    );
endinterface

// File: rtl/chimera_clu_gate_fsm.sv
// One cluster's gate/ungate sequencer with its shared down-counter.
// CHIMERA_CLU_GATE_TIMEOUT_EN adds a drain timeout with a sticky flag.
module chimera_clu_gate_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned SettleCycles  = CluGateSettleCycles,
    parameter int unsigned RstCycles     = CluGateRstCycles,
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    parameter int unsigned TimeoutCycles = CluGateTimeoutCycles,
`endif
    parameter int unsigned CntW          = 11
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_gate_req,
    input  logic i_busy,
    input  logic i_isolated,
    output logic o_isolate,
    output logic o_clk_en,
    output logic o_clu_rst_n,
    output logic o_gated,
    output logic o_timeout
);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] RstLoad    = CntW'(RstCycles - 1);

    clu_gate_state_e r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic w_drained, w_cnt_zero;
    logic r_isolate, r_clk_en, r_rst_n, r_gated;

    assign w_drained  = i_isolated & ~i_busy;
    assign w_cnt_zero = (r_cnt == '0);

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
    logic w_to_set;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
        w_to_set    = 1'b0;
`endif
        unique case (r_state)
            ACTIVE: begin
                if (i_gate_req) begin
                    w_state_nxt = ISOLATE;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
                    w_cnt_nxt   = TimeoutLoad;
`endif
                end
            end
            ISOLATE: begin
                // Abort wins over a drain completing in the same cycle
                if (!i_gate_req) begin
                    w_state_nxt = ACTIVE;
                end else if (w_drained) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = SettleLoad;
                end
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_state_nxt = ACTIVE;
                    w_to_set    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
`endif
            end
            SETTLE: begin
                if (w_cnt_zero) w_state_nxt = GATED;
                else            w_cnt_nxt   = r_cnt - CntW'(1);
            end
            GATED: begin
                if (!i_gate_req) begin
                    w_state_nxt = WAKE;
                    w_cnt_nxt   = RstLoad;
                end
            end
            WAKE: begin
                if (w_cnt_zero) w_state_nxt = ACTIVE;
                else            w_cnt_nxt   = r_cnt - CntW'(1);
            end
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ACTIVE;
            r_cnt     <= '0;
            r_isolate <= 1'b0;
            r_clk_en  <= 1'b1;
            r_rst_n   <= 1'b1;
            r_gated   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_isolate <= (w_state_nxt != ACTIVE);
            r_clk_en  <= (w_state_nxt != GATED);
            r_rst_n   <= (w_state_nxt != WAKE);
            r_gated   <= (w_state_nxt == GATED);
        end
    end

    assign o_isolate   = r_isolate;
    assign o_clk_en    = r_clk_en;
    assign o_clu_rst_n = r_rst_n;
    assign o_gated     = r_gated;

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    logic r_req_q, r_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_q   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_req_q <= i_gate_req;
            if (w_to_set)                   r_timeout <= 1'b1;
            else if (r_req_q & ~i_gate_req) r_timeout <= 1'b0;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/chimera_clu_gate_ctrl.sv
// Per-cluster clock-gate sequencer: one independent FSM per cluster.
// CHIMERA_CLU_GATE_TIMEOUT_EN enables the drain timeout in every FSM.
module chimera_clu_gate_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters   = 5,
    parameter int unsigned SettleCycles  = CluGateSettleCycles,
    parameter int unsigned RstCycles     = CluGateRstCycles,
    parameter int unsigned TimeoutCycles = CluGateTimeoutCycles
) (
    input logic                    soc_clk_i,
    input logic                    rst_ni,
    chimera_clu_gate_ctrl_if.slave bus
);
    localparam int unsigned CntW =
        clu_gate_cnt_w(SettleCycles, RstCycles, TimeoutCycles);

    logic [NumClusters-1:0] w_isolate, w_clk_en, w_rst_n;
    logic [NumClusters-1:0] w_gated, w_timeout;

    for (genvar g = 0; g < NumClusters; g++) begin : g_clu
        chimera_clu_gate_fsm #(
            .SettleCycles  (SettleCycles),
            .RstCycles     (RstCycles),
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
            .TimeoutCycles (TimeoutCycles),
`endif
            .CntW          (CntW)
        ) u_fsm (
            .i_clk       (soc_clk_i),
            .i_rst_n     (rst_ni),
            .i_gate_req  (bus.gate_req_i[g]),
            .i_busy      (bus.busy_i[g]),
            .i_isolated  (bus.isolated_i[g]),
            .o_isolate   (w_isolate[g]),
            .o_clk_en    (w_clk_en[g]),
            .o_clu_rst_n (w_rst_n[g]),
            .o_gated     (w_gated[g]),
            .o_timeout   (w_timeout[g])
        );
    end

    assign bus.isolate_o  = w_isolate;
    assign bus.clk_en_o   = w_clk_en;
    assign bus.clu_rst_no = w_rst_n;
    assign bus.gated_o    = w_gated;
    assign bus.timeout_o  = w_timeout;

endmodule

// File: tb/tb_chimera_clu_gate_ctrl.sv
// Scoreboard bench: output edges per cluster are predicted as timestamped
// events from the sequencing rules and matched by an edge-watching monitor.
module tb_chimera_clu_gate_ctrl;
    localparam int NC = 5;
    localparam int S  = 4;
    localparam int R  = 8;
    localparam int T  = 16;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam int DrainLong = 10;
`else
    localparam int DrainLong = 50;
`endif

    localparam int K_ISO_R = 0, K_ISO_F = 1, K_CLK_R = 2, K_CLK_F = 3;
    localparam int K_RST_R = 4, K_RST_F = 5, K_GAT_R = 6, K_GAT_F = 7;
    localparam int K_TO_R  = 8, K_TO_F  = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0] req  = '0;
    logic [NC-1:0] busy = '0;
    logic [NC-1:0] iso  = '0;

    always #5 clk = ~clk;

    chimera_clu_gate_ctrl_if #(.NumClusters(NC)) bus ();

    assign bus.gate_req_i = req;
    assign bus.busy_i     = busy;
    assign bus.isolated_i = iso;

    chimera_clu_gate_ctrl #(
        .NumClusters   (NC),
        .SettleCycles  (S),
        .RstCycles     (R),
        .TimeoutCycles (T)
    ) dut (
        .soc_clk_i (clk),
        .rst_ni    (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    int qc [NC][$];
    int qk [NC][$];

    logic [NC-1:0] p_iso, p_clk, p_rst, p_gat, p_to;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_ISO_R: return "isolate_rise";
            K_ISO_F: return "isolate_fall";
            K_CLK_R: return "clk_en_rise";
            K_CLK_F: return "clk_en_fall";
            K_RST_R: return "rst_n_rise";
            K_RST_F: return "rst_n_fall";
            K_GAT_R: return "gated_rise";
            K_GAT_F: return "gated_fall";
            K_TO_R:  return "timeout_rise";
            default: return "timeout_fall";
        endcase
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    task automatic expect_ev(int c, int k, int at);
        qc[c].push_back(at);
        qk[c].push_back(k);
    endtask

    task automatic observe(int c, int k);
        int idx;
        idx = -1;
        for (int i = 0; i < qk[c].size(); i++)
            if (idx < 0 && qk[c][i] == k) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL c%0d %s: seen at cycle %0d, required none",
                     c, kname(k), cyc);
        end else begin
            if (qc[c][idx] != cyc) begin
                errors++;
                $display("FAIL c%0d %s: seen at cycle %0d, required cycle %0d",
                         c, kname(k), cyc, qc[c][idx]);
            end
            qc[c].delete(idx);
            qk[c].delete(idx);
        end
    endtask

    task automatic overdue(int c);
        int i;
        i = 0;
        while (i < qc[c].size()) begin
            if (qc[c][i] < cyc) begin
                checks++;
                errors++;
                $display("FAIL c%0d %s: not seen by cycle %0d, required at cycle %0d",
                         c, kname(qk[c][i]), cyc, qc[c][i]);
                qc[c].delete(i);
                qk[c].delete(i);
            end else begin
                i++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NC; c++) begin
                if (bus.isolate_o[c] !== p_iso[c])
                    observe(c, bus.isolate_o[c] ? K_ISO_R : K_ISO_F);
                if (bus.clk_en_o[c] !== p_clk[c])
                    observe(c, bus.clk_en_o[c] ? K_CLK_R : K_CLK_F);
                if (bus.clu_rst_no[c] !== p_rst[c])
                    observe(c, bus.clu_rst_no[c] ? K_RST_R : K_RST_F);
                if (bus.gated_o[c] !== p_gat[c])
                    observe(c, bus.gated_o[c] ? K_GAT_R : K_GAT_F);
                if (bus.timeout_o[c] !== p_to[c])
                    observe(c, bus.timeout_o[c] ? K_TO_R : K_TO_F);
                overdue(c);
            end
        end
        p_iso = bus.isolate_o;
        p_clk = bus.clk_en_o;
        p_rst = bus.clu_rst_no;
        p_gat = bus.gated_o;
        p_to  = bus.timeout_o;
    end

    task automatic chk(string name, logic [NC-1:0] got, logic [NC-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_isolate"}, bus.isolate_o, '0);
        chk({tag, "_clk_en"}, bus.clk_en_o, '1);
        chk({tag, "_rst_n"}, bus.clu_rst_no, '1);
        chk({tag, "_gated"}, bus.gated_o, '0);
        chk({tag, "_timeout"}, bus.timeout_o, '0);
    endtask

    // Full gate then ungate; drain completes db/di cycles after the request.
    task automatic gate_seq(int c, int db, int di, int hold);
        int n, d, m, mx;
        @(negedge clk);
        n = cyc;
        req[c]  = 1'b1;
        busy[c] = (db > 0);
        iso[c]  = (di == 0);
        mx = max3(0, db, di);
        d  = n + 1 + max3(1, db, di);
        expect_ev(c, K_ISO_R, n + 1);
        expect_ev(c, K_CLK_F, d + S);
        expect_ev(c, K_GAT_R, d + S);
        for (int k = 1; k <= mx; k++) begin
            @(negedge clk);
            if (k == db) busy[c] = 1'b0;
            if (k == di) iso[c] = 1'b1;
        end
        while (cyc < d + S + hold) @(negedge clk);
        m = cyc;
        req[c] = 1'b0;
        expect_ev(c, K_CLK_R, m + 1);
        expect_ev(c, K_RST_F, m + 1);
        expect_ev(c, K_GAT_F, m + 1);
        expect_ev(c, K_RST_R, m + 1 + R);
        expect_ev(c, K_ISO_F, m + 1 + R);
        while (cyc < m + R + 3) @(negedge clk);
        iso[c] = 1'b0;
    endtask

    // Request held p cycles while the cluster stays busy: aborts back to ACTIVE.
    task automatic abort_seq(int c, int p);
        int n;
        @(negedge clk);
        n = cyc;
        req[c]  = 1'b1;
        busy[c] = 1'b1;
        iso[c]  = 1'($urandom_range(0, 1));
        expect_ev(c, K_ISO_R, n + 1);
        while (cyc < n + p) @(negedge clk);
        req[c] = 1'b0;
        expect_ev(c, K_ISO_F, n + p + 1);
        @(negedge clk);
        busy[c] = 1'b0;
        iso[c]  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    task automatic timeout_seq(int c);
        int n;
        @(negedge clk);
        n = cyc;
        req[c]  = 1'b1;
        busy[c] = 1'b1;
        iso[c]  = 1'b1;
        expect_ev(c, K_ISO_R, n + 1);
        expect_ev(c, K_ISO_F, n + T + 1);
        expect_ev(c, K_TO_R, n + T + 1);
        while (cyc < n + T + 1) @(negedge clk);
        chk("timeout_flag", bus.timeout_o & NC'(1 << c), NC'(1 << c));
        chk("timeout_clk_en", bus.clk_en_o & NC'(1 << c), NC'(1 << c));
        req[c] = 1'b0;
        expect_ev(c, K_TO_F, n + T + 2);
        @(negedge clk);
        busy[c] = 1'b0;
        iso[c]  = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("after_reset");
        mon_en = 1'b1;

        fork
            gate_seq(0, DrainLong, 0, 3);
            gate_seq(2, 0, 1, 4);
        join
        abort_seq(1, 3);
        gate_seq(3, 0, 0, 2);

        for (int it = 0; it < 14; it++) begin
            int c;
            c = $urandom_range(0, NC - 1);
            if ($urandom_range(0, 2) == 0)
                abort_seq(c, $urandom_range(1, 6));
            else
                gate_seq(c, $urandom_range(0, 12), $urandom_range(0, 3),
                         $urandom_range(0, 5));
        end

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
        timeout_seq(4);
`endif

        // Reset while cluster 2 sits in SETTLE
        @(negedge clk);
        req[2] = 1'b1;
        iso[2] = 1'b1;
        expect_ev(2, K_ISO_R, cyc + 1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        for (int c = 0; c < NC; c++) begin
            qc[c].delete();
            qk[c].delete();
        end
        req = '0;
        iso = '0;
        busy = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        gate_seq(4, 2, 1, 1);

        repeat (5) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (qc[c].size() != 0) begin
                errors++;
                $display("FAIL c%0d pending: %0d events left, required 0",
                         c, qc[c].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
